// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-granular round-robin arbiter sharing one uart_tx among N_REQ byte streams
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int PAYLOAD_BITS = 8,
    parameter int BUSY_TIMEOUT = 4,
    parameter int GAP_TIMEOUT  = 1024
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ-1:0]              req_last,
    input  logic [N_REQ*PAYLOAD_BITS-1:0] req_data,
    output logic [N_REQ-1:0]              req_ready,
    output logic                          uart_tx_en,
    output logic [PAYLOAD_BITS-1:0]       uart_tx_data,
    input  logic                          uart_tx_busy,
    output logic [$clog2(N_REQ)-1:0]      grant_id,
    output logic                          pkt_active,
    output logic                          err
);

    localparam int IDW  = $clog2(N_REQ);
    localparam int MAXT = (BUSY_TIMEOUT > GAP_TIMEOUT) ? BUSY_TIMEOUT : GAP_TIMEOUT;
    localparam int CW   = $clog2(MAXT) + 1;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_BUSY,
        WAIT_DONE,
        HOLD
    } state_t;

    state_t                  state_q;
    logic [IDW-1:0]          rr_ptr_q;
    logic [IDW-1:0]          grant_q;
    logic [CW-1:0]           cnt_q;
    logic                    last_q;
    logic                    tx_en_q;
    logic [PAYLOAD_BITS-1:0] tx_data_q;
    logic [N_REQ-1:0]        ready_q;
    logic                    pkt_q;
    logic                    err_q;

    logic [PAYLOAD_BITS-1:0] data_arr [N_REQ];
    logic                    win_found;
    logic [IDW-1:0]          win_idx;
    logic [IDW-1:0]          sel_d;
    logic                    load_d;
    logic [CW-1:0]           cnt_inc;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign data_arr[g] = req_data[g*PAYLOAD_BITS +: PAYLOAD_BITS];
    end

    // Scan starting just after the last winner so a finished owner gets lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            int j;
            j = (int'(rr_ptr_q) + k) % N_REQ;
            if (!win_found && req_valid[j[IDW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = j[IDW-1:0];
            end
        end
    end

    always_comb begin
        sel_d   = (state_q == HOLD) ? grant_q : win_idx;
        load_d  = ((state_q == IDLE) && win_found) ||
                  ((state_q == HOLD) && req_valid[grant_q]);
        cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            rr_ptr_q  <= IDW'(N_REQ - 1);
            grant_q   <= '0;
            cnt_q     <= '0;
            last_q    <= 1'b0;
            tx_en_q   <= 1'b0;
            tx_data_q <= '0;
            ready_q   <= '0;
            pkt_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            tx_en_q <= 1'b0;
            ready_q <= '0;
            case (state_q)
                IDLE, HOLD: begin
                    if (load_d) begin
                        grant_q   <= sel_d;
                        pkt_q     <= 1'b1;
                        tx_en_q   <= 1'b1;
                        tx_data_q <= data_arr[sel_d];
                        ready_q   <= {{(N_REQ-1){1'b0}}, 1'b1} << sel_d;
                        last_q    <= req_last[sel_d];
                        state_q   <= SEND;
                    end else if (state_q == HOLD) begin
                        if (cnt_q >= CW'(GAP_TIMEOUT - 1)) begin
                            err_q    <= 1'b1;
                            pkt_q    <= 1'b0;
                            rr_ptr_q <= grant_q;
                            state_q  <= IDLE;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                end
                SEND: begin
                    cnt_q   <= '0;
                    state_q <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (uart_tx_busy) begin
                        state_q <= WAIT_DONE;
                    end else if (cnt_q >= CW'(BUSY_TIMEOUT - 1)) begin
                        err_q    <= 1'b1;
                        pkt_q    <= 1'b0;
                        rr_ptr_q <= grant_q;
                        state_q  <= IDLE;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                WAIT_DONE: begin
                    if (!uart_tx_busy) begin
                        if (last_q) begin
                            rr_ptr_q <= grant_q;
                            pkt_q    <= 1'b0;
                            state_q  <= IDLE;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= HOLD;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready    = ready_q;
    assign uart_tx_en   = tx_en_q;
    assign uart_tx_data = tx_data_q;
    assign grant_id     = grant_q;
    assign pkt_active   = pkt_q;
    assign err          = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a behavioural uart_tx line model
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int PB  = 8;
    localparam int BT  = 4;
    localparam int GT  = 1024;
    localparam int CPB = 4;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_last = '0;
    logic [N*PB-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            uart_tx_en;
    logic [PB-1:0]   uart_tx_data;
    logic            uart_tx_busy;
    logic [1:0]      grant_id;
    logic            pkt_active;
    logic            err;

    uart_tx_arbiter #(.N_REQ(N), .PAYLOAD_BITS(PB), .BUSY_TIMEOUT(BT), .GAP_TIMEOUT(GT)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_last(req_last),
        .req_data(req_data), .req_ready(req_ready), .uart_tx_en(uart_tx_en),
        .uart_tx_data(uart_tx_data), .uart_tx_busy(uart_tx_busy), .grant_id(grant_id),
        .pkt_active(pkt_active), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [8:0] rq [N][$];
    logic [7:0] exp_byte [$];
    logic [1:0] exp_grant [$];
    int         rdy_cnt [N];
    int         en_cnt = 0;

    logic       model_on = 1'b1;
    logic       m_busy;
    logic       m_line;
    logic [9:0] m_frame;
    int         m_bit;
    int         m_cyc;
    logic [7:0] rx;
    logic       prev_en = 1'b0;
    logic       prev_pkt = 1'b0;

    assign uart_tx_busy = model_on ? m_busy : 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_busy <= 1'b0;
            m_line <= 1'b1;
            m_bit  <= 0;
            m_cyc  <= 0;
        end else if (m_busy) begin
            if (m_cyc == CPB - 1) begin
                m_cyc <= 0;
                if (m_bit == 9) begin
                    m_busy <= 1'b0;
                    m_line <= 1'b1;
                end else begin
                    m_bit  <= m_bit + 1;
                    m_line <= m_frame[m_bit+1];
                end
            end else begin
                m_cyc <= m_cyc + 1;
            end
        end else if (uart_tx_en && model_on) begin
            m_frame <= {1'b1, uart_tx_data, 1'b0};
            m_line  <= 1'b0;
            m_busy  <= 1'b1;
            m_bit   <= 0;
            m_cyc   <= 0;
        end
    end

    initial begin : driver
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (req_ready[i] && rq[i].size() > 0) begin
                    void'(rq[i].pop_front());
                    rdy_cnt[i]++;
                end
                req_valid[i]          = (rq[i].size() > 0);
                req_last[i]           = (rq[i].size() > 0) ? rq[i][0][8] : 1'b0;
                req_data[i*PB +: PB]  = (rq[i].size() > 0) ? rq[i][0][7:0] : 8'h00;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (resetn && uart_tx_en) begin
                en_cnt++;
                chk("en_while_busy", {31'd0, m_busy}, 0);
                chk("en_single_cycle", {31'd0, prev_en}, 0);
                if (exp_grant.size() == 0) begin
                    chk("unexpected_grant", 1, 0);
                end else begin
                    logic [1:0] g;
                    g = exp_grant.pop_front();
                    chk("grant_id", {30'd0, grant_id}, {30'd0, g});
                    chk("ready_aligned", {28'd0, req_ready}, 32'd1 << g);
                end
            end else if (req_ready != '0) begin
                chk("ready_without_en", {28'd0, req_ready}, 0);
            end
            if (prev_pkt && !pkt_active && !err)
                chk("pkt_fall_busy", {31'd0, m_busy}, 0);
            if (m_busy && m_cyc == CPB / 2) begin
                if (m_bit == 0) begin
                    chk("start_bit", {31'd0, m_line}, 0);
                end else if (m_bit <= 8) begin
                    rx[m_bit-1] = m_line;
                end else begin
                    chk("stop_bit", {31'd0, m_line}, 1);
                    if (exp_byte.size() == 0) chk("unexpected_byte", {24'd0, rx}, 32'hFFFF_FFFF);
                    else                      chk("line_byte", {24'd0, rx}, {24'd0, exp_byte.pop_front()});
                end
            end
            prev_en  = uart_tx_en;
            prev_pkt = pkt_active;
        end
    end

    task automatic push(input int r, input logic [7:0] b, input logic l);
        rq[r].push_back({l, b});
    endtask

    task automatic expect_tx(input int r, input logic [7:0] b);
        exp_grant.push_back(2'(r));
        exp_byte.push_back(b);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        for (int i = 0; i < N; i++) begin
            rq[i].delete();
            rdy_cnt[i] = 0;
        end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int lim);
        int  n;
        logic busy_any;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            busy_any = pkt_active || m_busy || uart_tx_en;
            for (int i = 0; i < N; i++) if (rq[i].size() > 0) busy_any = 1'b1;
        end while (busy_any && n < lim);
        if (n >= lim) chk("idle_timeout", 0, 1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        int n;
        int snap;
        for (int i = 0; i < N; i++) rdy_cnt[i] = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_en", {31'd0, uart_tx_en}, 0);
        chk("rst_ready", {28'd0, req_ready}, 0);
        chk("rst_pkt", {31'd0, pkt_active}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_grant", {30'd0, grant_id}, 0);
        chk("rst_data", {24'd0, uart_tx_data}, 0);
        do_reset();

        // single requester, two-byte packet
        snap = en_cnt;
        push(0, 8'h55, 1'b0); push(0, 8'hA3, 1'b1);
        expect_tx(0, 8'h55); expect_tx(0, 8'hA3);
        wait_idle(400);
        chk("t1_en_count", en_cnt - snap, 2);
        chk("t1_ready_count", rdy_cnt[0], 2);

        // two contending packets, then a full round from rr_ptr=2
        do_reset();
        push(0, 8'h10, 1'b0); push(0, 8'h11, 1'b1);
        push(2, 8'h20, 1'b0); push(2, 8'h21, 1'b1);
        expect_tx(0, 8'h10); expect_tx(0, 8'h11); expect_tx(2, 8'h20); expect_tx(2, 8'h21);
        wait_idle(800);
        for (int i = 0; i < N; i++) push(i, 8'h30 + 8'(i), 1'b1);
        expect_tx(3, 8'h33); expect_tx(0, 8'h30); expect_tx(1, 8'h31); expect_tx(2, 8'h32);
        wait_idle(800);

        // three rounds of single-byte packets from everyone
        do_reset();
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < N; i++) begin
                push(i, 8'h40 + 8'(r*4 + i), 1'b1);
                expect_tx(i, 8'h40 + 8'(r*4 + i));
            end
        wait_idle(2000);
        chk("t6_ready_r3", rdy_cnt[3], 3);

        // mid-packet stall triggers gap abort; pending requester 0 served next
        do_reset();
        push(1, 8'h77, 1'b0);
        expect_tx(1, 8'h77);
        n = 0;
        while (!pkt_active && n < 20) begin @(negedge clk); n++; end
        chk("t3_granted", {31'd0, pkt_active}, 1);
        @(posedge clk); #1;
        push(0, 8'h66, 1'b1);
        expect_tx(0, 8'h66);
        n = 0;
        while (!err && n < GT + 200) begin @(negedge clk); n++; end
        chk("t3_err", {31'd0, err}, 1);
        chk("t3_pkt_released", {31'd0, pkt_active}, 0);
        wait_idle(400);
        chk("t3_err_sticky", {31'd0, err}, 1);

        // busy never rises: timeout, grant released, no extra strobes
        do_reset();
        model_on = 1'b0;
        snap = en_cnt;
        push(2, 8'h99, 1'b1);
        exp_grant.push_back(2'd2);
        n = 0;
        while (!uart_tx_en && n < 20) begin @(negedge clk); n++; end
        chk("t4_en_seen", {31'd0, uart_tx_en}, 1);
        n = 0;
        while (!err && n < 50) begin @(negedge clk); n++; end
        chk("t4_err", {31'd0, err}, 1);
        chk("t4_timeout_window", {31'd0, (n >= BT && n <= BT + 1)}, 1);
        chk("t4_pkt", {31'd0, pkt_active}, 0);
        repeat (20) @(negedge clk);
        chk("t4_no_more_en", en_cnt - snap, 1);
        model_on = 1'b1;

        // asynchronous reset in the middle of a byte
        push(1, 8'h5A, 1'b1);
        exp_grant.push_back(2'd1);
        n = 0;
        while (!m_busy && n < 30) begin @(negedge clk); n++; end
        chk("t5_busy", {31'd0, m_busy}, 1);
        repeat (10) @(negedge clk);
        chk("t5_pre_grant", {30'd0, grant_id}, 1);
        #2 resetn = 1'b0;
        #1;
        chk("t5_en", {31'd0, uart_tx_en}, 0);
        chk("t5_ready", {28'd0, req_ready}, 0);
        chk("t5_pkt", {31'd0, pkt_active}, 0);
        chk("t5_err", {31'd0, err}, 0);
        chk("t5_grant", {30'd0, grant_id}, 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        push(3, 8'hC3, 1'b1); push(0, 8'hC0, 1'b1);
        expect_tx(0, 8'hC0); expect_tx(3, 8'hC3);
        wait_idle(400);

        chk("sb_bytes_left", exp_byte.size(), 0);
        chk("sb_grants_left", exp_grant.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
